// File: rtl/pic_cascade_init.sv
// Programs a cascaded 8259 group (master + N_SLAVES slaves) with ICW1-4, OCW1, OCW3, one device at a time.
// Each write takes STROBE_LEN+3 cycles: SETUP, STROBE_LEN cycles of STROBE, HOLD, GAP. start is ignored while busy.
module pic_cascade_init #(
    parameter int         N_SLAVES    = 6,
    parameter logic [7:0] VECTOR_BASE = 8'h08,
    parameter logic [7:0] VECTOR_STEP = 8'h08,
    parameter int         STROBE_LEN  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ltim,
    input  logic              aeoi,
    input  logic [7:0]        imr_master,
    input  logic [7:0]        imr_slave,
    output logic [N_SLAVES:0] chip_select,
    output logic              A0,
    output logic              write_flag,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic              busy,
    output logic              done,
    output logic [3:0]        dev_idx,
    output logic [2:0]        step
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_t;

    localparam logic [7:0] VB          = VECTOR_BASE & 8'hF8;
    localparam logic [7:0] VS          = VECTOR_STEP & 8'hF8;
    localparam logic [7:0] MASTER_ICW3 = 8'((9'd1 << N_SLAVES) - 9'd1);
    localparam logic [3:0] LAST_DEV    = 4'(N_SLAVES);
    localparam logic [3:0] STB_LAST    = 4'(STROBE_LEN - 1);

    state_t            state_q, state_d;
    logic [3:0]        dev_q, dev_d;
    logic [2:0]        step_q, step_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ltim_q, ltim_d;
    logic              aeoi_q, aeoi_d;
    logic [7:0]        imr_m_q, imr_m_d;
    logic [7:0]        imr_s_q, imr_s_d;
    logic [N_SLAVES:0] cs_q, cs_d;
    logic              a0_q, a0_d;
    logic              wf_q, wf_d;
    logic [7:0]        dout_q, dout_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drive;

    always_comb begin
        state_d = state_q;
        dev_d   = dev_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        ltim_d  = ltim_q;
        aeoi_d  = aeoi_q;
        imr_m_d = imr_m_q;
        imr_s_d = imr_s_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ltim_d  = ltim;
                    aeoi_d  = aeoi;
                    imr_m_d = imr_master;
                    imr_s_d = imr_slave;
                    dev_d   = 4'd0;
                    step_d  = 3'd0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = STB_LAST;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) state_d = S_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_HOLD: state_d = S_GAP;
            S_GAP: begin
                if (step_q < 3'd5) begin
                    step_d  = step_q + 3'd1;
                    state_d = S_SETUP;
                end else if (dev_q < LAST_DEV) begin
                    dev_d   = dev_q + 4'd1;
                    step_d  = 3'd0;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so every pin comes straight from a flop.
        drive  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        cs_d   = '1;
        a0_d   = 1'b0;
        dout_d = 8'h00;
        if (drive) begin
            for (int i = 0; i <= N_SLAVES; i++) begin
                if (dev_d == 4'(i)) cs_d[i] = 1'b0;
            end
            case (step_d)
                3'd0: dout_d = {3'b000, 1'b1, ltim_d, 3'b001};
                3'd1: begin
                    a0_d   = 1'b1;
                    dout_d = VB + VS * {4'b0000, dev_d};
                end
                3'd2: begin
                    a0_d   = 1'b1;
                    dout_d = (dev_d == 4'd0) ? MASTER_ICW3 : {5'b00000, 3'(dev_d - 4'd1)};
                end
                3'd3: begin
                    a0_d   = 1'b1;
                    dout_d = {6'b000000, aeoi_d, 1'b1};
                end
                3'd4: begin
                    a0_d   = 1'b1;
                    dout_d = (dev_d == 4'd0) ? imr_m_d : imr_s_d;
                end
                default: dout_d = 8'h0B;
            endcase
        end
        wf_d   = (state_d != S_STROBE);
        oe_d   = drive;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dev_q   <= 4'd0;
            step_q  <= 3'd0;
            cnt_q   <= 4'd0;
            ltim_q  <= 1'b0;
            aeoi_q  <= 1'b0;
            imr_m_q <= 8'h00;
            imr_s_q <= 8'h00;
            cs_q    <= '1;
            a0_q    <= 1'b0;
            wf_q    <= 1'b1;
            dout_q  <= 8'h00;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dev_q   <= dev_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            ltim_q  <= ltim_d;
            aeoi_q  <= aeoi_d;
            imr_m_q <= imr_m_d;
            imr_s_q <= imr_s_d;
            cs_q    <= cs_d;
            a0_q    <= a0_d;
            wf_q    <= wf_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign chip_select = cs_q;
    assign A0          = a0_q;
    assign write_flag  = wf_q;
    assign data_out    = dout_q;
    assign data_oe     = oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dev_idx     = dev_q;
    assign step        = step_q;

endmodule
